// File: rtl/dmem.sv
// Byte-addressed little-endian RV32 data memory (LB/LBU/LH/LHU/LW, SB/SH/SW) placed after IMEM in the map.
// Loads return registered, extended data one clock after req; addr_err flags range/alignment/size faults.
package memory_pkg;
    localparam int unsigned DMEM_BYTES     = 4096;
    localparam int unsigned IMEM_BYTES     = 4096;
    localparam int unsigned MEM_ADDR_WIDTH = 32;
    localparam int unsigned MEM_WORD_WIDTH = 32;
    localparam logic [1:0]  LS_SINGLE      = 2'b00;
    localparam logic [1:0]  LS_HALFWORD    = 2'b01;
    localparam logic [1:0]  LS_WORD        = 2'b10;
endpackage

module dmem
    import memory_pkg::*;
#(
    parameter int unsigned DMEM_SIZE  = DMEM_BYTES,
    parameter int unsigned START_ADDR = IMEM_BYTES,
    parameter int unsigned ADDR_W     = MEM_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write_en,
    input  logic              l_unsigned,
    input  logic [1:0]        n_bytes,
    input  logic [31:0]       store_data,
    output logic              addr_err,
    output logic [31:0]       load_data
);
    localparam int unsigned WORD_W = MEM_WORD_WIDTH;
    localparam int unsigned AW1    = ADDR_W + 1;
    localparam int unsigned IDX_W  = $clog2(START_ADDR + DMEM_SIZE);
    localparam logic [AW1-1:0] FIRST_ADDR = AW1'(START_ADDR);
    localparam logic [AW1-1:0] LAST_ADDR  = AW1'(START_ADDR + DMEM_SIZE - 1);

    logic [7:0] dmem_ram [START_ADDR:START_ADDR+DMEM_SIZE-1];

    logic              load_err_q, load_err_d;
    logic [WORD_W-1:0] load_data_q, load_data_d;
    logic [AW1-1:0]    span, last_byte;
    logic              size_ok, align_ok, legal;
    logic [IDX_W-1:0]  idx0, idx1, idx2, idx3;
    logic [7:0]        b0, b1, b2, b3;
    logic [WORD_W-1:0] rdata;

    // Extra top bit keeps addr+span-1 from wrapping near the top of the address space.
    always_comb begin
        span     = AW1'(1);
        size_ok  = 1'b1;
        align_ok = 1'b1;
        case (n_bytes)
            LS_SINGLE:   span = AW1'(1);
            LS_HALFWORD: begin
                span     = AW1'(2);
                align_ok = ~addr[0];
            end
            LS_WORD: begin
                span     = AW1'(4);
                align_ok = (addr[1:0] == 2'b00);
            end
            default:     size_ok = 1'b0;
        endcase
        last_byte = {1'b0, addr} + span - AW1'(1);
        legal     = size_ok && align_ok && ({1'b0, addr} >= FIRST_ADDR) && (last_byte <= LAST_ADDR);
    end

    assign idx0 = addr[IDX_W-1:0];
    assign idx1 = idx0 + IDX_W'(1);
    assign idx2 = idx0 + IDX_W'(2);
    assign idx3 = idx0 + IDX_W'(3);

    always_comb begin
        b0    = dmem_ram[idx0];
        b1    = dmem_ram[idx1];
        b2    = dmem_ram[idx2];
        b3    = dmem_ram[idx3];
        rdata = {b3, b2, b1, b0};
        case (n_bytes)
            LS_SINGLE:   rdata = l_unsigned ? {24'h0, b0} : {{24{b0[7]}}, b0};
            LS_HALFWORD: rdata = l_unsigned ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default:     rdata = {b3, b2, b1, b0};
        endcase
    end

    // Storage is deliberately outside reset so preloaded images survive it.
    always_ff @(posedge clk) begin
        if (req && write_en && legal) begin
            dmem_ram[idx0] <= store_data[7:0];
            if (n_bytes != LS_SINGLE) begin
                dmem_ram[idx1] <= store_data[15:8];
            end
            if (n_bytes == LS_WORD) begin
                dmem_ram[idx2] <= store_data[23:16];
                dmem_ram[idx3] <= store_data[31:24];
            end
        end
    end

    always_comb begin
        load_data_d = load_data_q;
        load_err_d  = load_err_q;
        if (req) begin
            load_err_d = ~legal;
            if (!write_en) begin
                load_data_d = legal ? rdata : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data_q <= '0;
            load_err_q  <= 1'b0;
        end else begin
            load_data_q <= load_data_d;
            load_err_q  <= load_err_d;
        end
    end

    assign load_data = load_data_q;
    assign addr_err  = load_err_q;
endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem with hand-computed expectations.
module tb_dmem;
    localparam logic [31:0] S   = 32'd4096;
    localparam logic [31:0] SZ  = 32'd4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        write_en = 1'b0;
    logic        l_unsigned = 1'b0;
    logic [1:0]  n_bytes = 2'b00;
    logic [31:0] store_data = '0;
    logic        addr_err;
    logic [31:0] load_data;

    int n_vec = 0;
    int n_err = 0;

    dmem dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr       (addr),
        .write_en   (write_en),
        .l_unsigned (l_unsigned),
        .n_bytes    (n_bytes),
        .store_data (store_data),
        .addr_err   (addr_err),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic we, input logic uns, input logic [1:0] nb,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req        = 1'b1;
        write_en   = we;
        l_unsigned = uns;
        n_bytes    = nb;
        addr       = a;
        store_data = d;
        @(posedge clk);
        #1;
        req        = 1'b0;
        write_en   = $urandom_range(0, 1);
        n_bytes    = 2'($urandom_range(0, 3));
        addr       = $urandom;
        store_data = $urandom;
    endtask

    initial begin
        logic [63:0] str;
        logic [31:0] held;
        str = "DEADBEEF";

        #3;
        chk("reset load_data", load_data, 32'h0);
        chk("reset addr_err", {31'h0, addr_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) acc(1'b1, 1'b0, 2'b00, S + 32'(i), {24'hABCDEF, str[63-8*i -: 8]});
        for (int i = 0; i < 8; i++) begin
            acc(1'b0, 1'b0, 2'b00, S + 32'(i), 32'h0);
            chk("string LB data", load_data, {24'h0, str[63-8*i -: 8]});
            chk("string LB err", {31'h0, addr_err}, 32'h0);
        end

        acc(1'b1, 1'b0, 2'b10, S + 20, 32'h11223344);
        acc(1'b1, 1'b0, 2'b00, S + 20, 32'hDEADBEEF);
        acc(1'b0, 1'b0, 2'b00, S + 20, 32'h0);
        chk("LB sign", load_data, 32'hFFFFFFEF);
        acc(1'b0, 1'b1, 2'b00, S + 20, 32'h0);
        chk("LBU zero", load_data, 32'h000000EF);
        acc(1'b0, 1'b0, 2'b10, S + 20, 32'h0);
        chk("SB neighbours", load_data, 32'h112233EF);

        acc(1'b1, 1'b0, 2'b01, S + 24, 32'hDEADBEEF);
        chk("SH holds load_data", load_data, 32'h112233EF);
        acc(1'b0, 1'b0, 2'b01, S + 24, 32'h0);
        chk("LH sign", load_data, 32'hFFFFBEEF);
        acc(1'b0, 1'b1, 2'b01, S + 24, 32'h0);
        chk("LHU zero", load_data, 32'h0000BEEF);
        acc(1'b0, 1'b1, 2'b00, S + 24, 32'h0);
        chk("SH byte 24", load_data, 32'h000000EF);
        acc(1'b0, 1'b1, 2'b00, S + 25, 32'h0);
        chk("SH byte 25", load_data, 32'h000000BE);

        acc(1'b1, 1'b0, 2'b10, S + 28, 32'hDEADBEEF);
        acc(1'b0, 1'b1, 2'b10, S + 28, 32'h0);
        chk("LW", load_data, 32'hDEADBEEF);
        acc(1'b0, 1'b1, 2'b00, S + 31, 32'h0);
        chk("LBU byte 31", load_data, 32'h000000DE);
        acc(1'b1, 1'b0, 2'b10, S + 32, 32'h12345678);

        acc(1'b0, 1'b0, 2'b10, S - 4, 32'h0);
        chk("LW below err", {31'h0, addr_err}, 32'h1);
        chk("LW below data", load_data, 32'h0);
        acc(1'b0, 1'b0, 2'b10, S + 28, 32'h0);
        acc(1'b0, 1'b0, 2'b10, S + SZ - 2, 32'h0);
        chk("LW above err", {31'h0, addr_err}, 32'h1);
        chk("LW above data", load_data, 32'h0);
        acc(1'b0, 1'b0, 2'b01, S + 25, 32'h0);
        chk("LH misaligned err", {31'h0, addr_err}, 32'h1);
        acc(1'b0, 1'b0, 2'b10, S + 28, 32'h0);
        chk("LW err clears", {31'h0, addr_err}, 32'h0);
        acc(1'b1, 1'b0, 2'b10, S + 30, 32'hCAFEF00D);
        chk("SW misaligned err", {31'h0, addr_err}, 32'h1);
        chk("illegal SW holds data", load_data, 32'hDEADBEEF);
        acc(1'b0, 1'b0, 2'b10, S + 28, 32'h0);
        chk("SW+30 no write lo", load_data, 32'hDEADBEEF);
        acc(1'b0, 1'b0, 2'b10, S + 32, 32'h0);
        chk("SW+30 no write hi", load_data, 32'h12345678);
        acc(1'b0, 1'b0, 2'b11, S + 28, 32'h0);
        chk("size 11 err", {31'h0, addr_err}, 32'h1);
        chk("size 11 data", load_data, 32'h0);

        acc(1'b1, 1'b0, 2'b01, S + SZ - 2, 32'h7777A5C3);
        chk("SH top err", {31'h0, addr_err}, 32'h0);
        acc(1'b0, 1'b1, 2'b01, S + SZ - 2, 32'h0);
        chk("LHU top", load_data, 32'h0000A5C3);
        acc(1'b0, 1'b0, 2'b00, S + SZ - 1, 32'h0);
        chk("LB last byte", load_data, 32'hFFFFFFA5);

        acc(1'b0, 1'b0, 2'b10, S + 28, 32'h0);
        acc(1'b1, 1'b0, 2'b10, S + 30, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst data", load_data, 32'h0);
        chk("async rst err", {31'h0, addr_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        acc(1'b0, 1'b0, 2'b10, S + 28, 32'h0);
        chk("LW after reset", load_data, 32'hDEADBEEF);
        held = load_data;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("idle data hold", load_data, 32'hDEADBEEF);
            chk("idle err hold", {31'h0, addr_err}, 32'h0);
        end
        chk("idle vs last load", load_data, held);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
